dcache_qspi: RTL
================

Name: dcache_qspi

Overview:
- Line-transfer engine directly below the data cache.
- On a cache miss it optionally writes back the dirty victim line, then fetches the missing line from a quad-SPI PSRAM.
- Cache side: nibble-serial, using the cache's dread/dwrite nibble bus and the wstrobe_d/rstrobe_d burst strobes.
- Because the cache nibble offset resets whenever its strobe drops, every cache-side transfer is a single unbroken burst of 2*LINE_LENGTH cycles. A full-line buffer decouples those bursts from the slower serial link.

Parameters:
LINE_LENGTH, 4, cache line length in bytes; NN = 2*LINE_LENGTH nibbles per line
PA, 22, physical address width in bits; PA <= 24
READ_WAIT, 6, dummy SCLK periods between read address and read data
CS_GAP, 2, minimum clk cycles cs_n is held high between two transactions

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
req  in  1  miss request (the cache's pull); sampled only in IDLE
push  in  1  victim is dirty and needs writeback (the cache's push); sampled with req
victim_tag  in  PA-log2(LINE_LENGTH)  line address of the resident victim (the cache's tag output)
miss_tag  in  PA-log2(LINE_LENGTH)  line address of the missing line (paddr[PA-1:log2(LINE_LENGTH)])
dwrite  in  4  victim nibble from the cache at its current offset
dread  out  4  fill nibble to the cache
wstrobe_d  out  1  fill burst strobe; the cache writes dread each cycle it is high
rstrobe_d  out  1  writeback burst strobe; the cache advances dwrite each cycle it is high
busy  out  1  high from request acceptance until the cycle before done
done  out  1  one-cycle pulse when the line is fully installed
sclk  out  1  QSPI clock (clk/2 during transactions, 0 when idle)
cs_n  out  1  QSPI chip select, active low
io_out  out  4  QSPI data out
io_oe  out  1  QSPI output enable
io_in  in  4  QSPI data in

Behaviour:
- Reset values:
  - Outputs: cs_n=1, sclk=0, io_oe=0, io_out=0, rstrobe_d=0, wstrobe_d=0, dread=0, busy=0, done=0.
  - State: IDLE; line buffer contents are don't-care.
- Reset mid-operation: same values the next cycle; the PSRAM transaction is abandoned and cs_n rises immediately.
- Acceptance:
  - In IDLE, req=1 at a rising edge is accepted.
  - victim_tag, miss_tag and push are latched; busy=1 from the next cycle.
  - req is ignored while busy.
  - The cache holds paddr stable until done.
- Address formation: byte address = {tag, log2(LINE_LENGTH) zero bits}, zero-extended to 24 bits, sent as 6 nibbles MSB-first.
- Wire timing:
  - Each wire nibble occupies 2 clk cycles.
  - Phase A: sclk=0, io_out driven.
  - Phase B: sclk=1; io_in is registered at the edge ending phase B.
  - Command is QPI: 2 nibbles, high nibble first.
- Nibble ordering: line byte k goes on the wire as cache nibble 2k+1 first, then 2k (high nibble first). Cache nibble n is byte n/2, low nibble when n is even.
- FSM:
  - IDLE -> (push ? WB_LOAD : RD_CMD).
  - WB_LOAD: NN consecutive cycles with rstrobe_d=1; dwrite is captured each cycle into buffer slot 0..NN-1; then WB_CMD.
  - WB_CMD (0x38) -> WB_ADDR (victim address) -> WB_DATA (NN nibbles, io_oe=1 throughout) -> GAP.
  - GAP: cs_n=1 for CS_GAP cycles -> RD_CMD.
  - RD_CMD (0xEB) -> RD_ADDR (miss address).
  - RD_WAIT: READ_WAIT SCLK periods, io_oe=0, sclk still toggling.
  - RD_DATA: NN nibbles into the buffer; then cs_n=1 -> FILL.
  - FILL: NN consecutive cycles with wstrobe_d=1; dread = buffer slot 0..NN-1 in order -> DONE.
  - DONE: done=1 and busy=0 for one cycle -> IDLE; a new req can be accepted in that IDLE cycle.
- cs_n is low from the first cycle of WB_CMD or RD_CMD through the last phase B of that transaction's data.
- io_oe=1 during CMD, ADDR and WB_DATA; 0 otherwise.
- rstrobe_d and wstrobe_d are never high together and never broken within a burst.
- Latency (default parameters, req accepted at edge t0):
  - Fill-only: cs_n low t0+1..t0+44; wstrobe_d t0+45..t0+52; done at t0+53.
  - With writeback: rstrobe_d t0+1..t0+8; write cs_n low t0+9..t0+40; gap t0+41..t0+42; read cs_n low t0+43..t0+86; wstrobe_d t0+87..t0+94; done at t0+95.

Test Plan:
- Fill-only: req=1, push=0, miss_tag=0x12345; the model returns line bytes 0xA1,0xB2,0xC3,0xD4 -> wire cmd nibbles E,B; address nibbles 0,4,8,D,1,4; dread during wstrobe_d = 1,A,2,B,3,C,4,D; done at t0+53.
- Writeback+fill: push=1, victim_tag=0x00007, dwrite bursts 0..F... over 8 strobes -> write cmd 3,8; address 0,0,0,0,1,C; data nibbles 1,0,3,2,5,4,7,6; cs_n high exactly 2 cycles; done at t0+95.
- req held high during busy and pulsed again at the done cycle -> no second acceptance while busy; a new transaction starts the cycle after done.
- reset asserted at t0+20 of a fill -> next cycle cs_n=1, io_oe=0, busy=0, no strobes; a fresh req then completes normally.
- Strobe integrity -> rstrobe_d asserted for exactly 8 contiguous cycles; wstrobe_d for exactly 8 contiguous cycles; never overlapping; io_oe=0 for all READ_WAIT and read-data nibbles.

Source files
------------

// File: rtl/dcache_qspi.sv
// rtl/dcache_qspi.sv - cache line transfer engine: optional dirty-victim writeback, then line fill over quad-SPI PSRAM
module dcache_qspi #(
  parameter int LINE_LENGTH = 4,
  parameter int PA          = 22,
  parameter int READ_WAIT   = 6,
  parameter int CS_GAP      = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                req,
  input  logic                                push,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]   victim_tag,
  input  logic [PA-$clog2(LINE_LENGTH)-1:0]   miss_tag,
  input  logic [3:0]                          dwrite,
  output logic [3:0]                          dread,
  output logic                                wstrobe_d,
  output logic                                rstrobe_d,
  output logic                                busy,
  output logic                                done,
  output logic                                sclk,
  output logic                                cs_n,
  output logic [3:0]                          io_out,
  output logic                                io_oe,
  input  logic [3:0]                          io_in
);
  localparam int NN = 2 * LINE_LENGTH;
  localparam int OW = $clog2(LINE_LENGTH);
  localparam int TW = PA - OW;
  localparam int IW = $clog2(NN);
  localparam int CW = 8;
  localparam logic [CW-1:0] NN_LAST   = CW'(NN - 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(READ_WAIT - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);
  localparam logic [CW-1:0] CMD_LAST  = CW'(1);
  localparam logic [CW-1:0] ADDR_LAST = CW'(5);

  typedef enum logic [3:0] {
    S_IDLE, S_WB_LOAD, S_WB_CMD, S_WB_ADDR, S_WB_DATA, S_GAP,
    S_RD_CMD, S_RD_ADDR, S_RD_WAIT, S_RD_DATA, S_FILL, S_DONE
  } state_t;

  state_t          state, state_n;
  logic            phase, phase_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [3:0]      line_buf [NN];
  logic [TW-1:0]   victim_q, miss_q;
  logic [IW-1:0]   slot, slot_sw;
  logic            wire_st;
  logic [CW-1:0]   wire_last;
  state_t          wire_next;

  // Line byte k travels high nibble first, so wire nibble j maps to buffer slot j^1.
  assign slot    = cnt[IW-1:0];
  assign slot_sw = slot ^ {{(IW-1){1'b0}}, 1'b1};

  function automatic logic [3:0] addr_nib(input logic [TW-1:0] tag, input logic [2:0] idx);
    logic [23:0] a;
    a = 24'({tag, {OW{1'b0}}});
    case (idx)
      3'd0:    addr_nib = a[23:20];
      3'd1:    addr_nib = a[19:16];
      3'd2:    addr_nib = a[15:12];
      3'd3:    addr_nib = a[11:8];
      3'd4:    addr_nib = a[7:4];
      3'd5:    addr_nib = a[3:0];
      default: addr_nib = 4'h0;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      phase <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      phase <= phase_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk) begin
    if (state == S_IDLE && req) begin
      victim_q <= victim_tag;
      miss_q   <= miss_tag;
    end
    if (state == S_WB_LOAD)
      line_buf[slot] <= dwrite;
    if (state == S_RD_DATA && phase)
      line_buf[slot_sw] <= io_in;
  end

  always_comb begin
    state_n   = state;
    phase_n   = 1'b0;
    cnt_n     = cnt;
    cs_n      = 1'b1;
    sclk      = 1'b0;
    io_oe     = 1'b0;
    io_out    = 4'h0;
    rstrobe_d = 1'b0;
    wstrobe_d = 1'b0;
    dread     = 4'h0;
    busy      = 1'b1;
    done      = 1'b0;
    wire_st   = 1'b0;
    wire_last = CMD_LAST;
    wire_next = S_IDLE;
    case (state)
      S_IDLE: begin
        busy  = 1'b0;
        cnt_n = '0;
        if (req) state_n = push ? S_WB_LOAD : S_RD_CMD;
      end
      S_WB_LOAD: begin
        rstrobe_d = 1'b1;
        cnt_n     = cnt + 1'b1;
        if (cnt == NN_LAST) begin
          state_n = S_WB_CMD;
          cnt_n   = '0;
        end
      end
      S_WB_CMD: begin
        io_oe = 1'b1; io_out = cnt[0] ? 4'h8 : 4'h3;
        wire_st = 1'b1; wire_last = CMD_LAST; wire_next = S_WB_ADDR;
      end
      S_WB_ADDR: begin
        io_oe = 1'b1; io_out = addr_nib(victim_q, cnt[2:0]);
        wire_st = 1'b1; wire_last = ADDR_LAST; wire_next = S_WB_DATA;
      end
      S_WB_DATA: begin
        io_oe = 1'b1; io_out = line_buf[slot_sw];
        wire_st = 1'b1; wire_last = NN_LAST; wire_next = S_GAP;
      end
      S_GAP: begin
        cnt_n = cnt + 1'b1;
        if (cnt == GAP_LAST) begin
          state_n = S_RD_CMD;
          cnt_n   = '0;
        end
      end
      S_RD_CMD: begin
        io_oe = 1'b1; io_out = cnt[0] ? 4'hB : 4'hE;
        wire_st = 1'b1; wire_last = CMD_LAST; wire_next = S_RD_ADDR;
      end
      S_RD_ADDR: begin
        io_oe = 1'b1; io_out = addr_nib(miss_q, cnt[2:0]);
        wire_st = 1'b1; wire_last = ADDR_LAST; wire_next = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        wire_st = 1'b1; wire_last = WAIT_LAST; wire_next = S_RD_DATA;
      end
      S_RD_DATA: begin
        wire_st = 1'b1; wire_last = NN_LAST; wire_next = S_FILL;
      end
      S_FILL: begin
        wstrobe_d = 1'b1;
        dread     = line_buf[slot];
        cnt_n     = cnt + 1'b1;
        if (cnt == NN_LAST) begin
          state_n = S_DONE;
          cnt_n   = '0;
        end
      end
      S_DONE: begin
        busy    = 1'b0;
        done    = 1'b1;
        cnt_n   = '0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    // Every wire nibble is phase A (sclk low) then phase B (sclk high); counters step after phase B.
    if (wire_st) begin
      cs_n    = 1'b0;
      sclk    = phase;
      phase_n = ~phase;
      if (phase) begin
        if (cnt == wire_last) begin
          cnt_n   = '0;
          state_n = wire_next;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
    end
  end
endmodule
